// File: rtl/id_stage_if.sv
// Decode-stage bus: instruction/PC/write-back inputs and the decoded operands and controls.
interface id_stage_if;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [31:0] wdi;
    logic        rsrtequ;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [2:0]  aluc;
    logic        m2reg;
    logic        wmem;
    logic        aluimm;
    logic        shift;

    modport master (
        output pc4, inst, wdi, rsrtequ,
        input  bpc, jpc, a, b, imm, aluc, m2reg, wmem, aluimm, shift
    );

    modport slave (
        input  pc4, inst, wdi, rsrtequ,
        output bpc, jpc, a, b, imm, aluc, m2reg, wmem, aluimm, shift
    );
endinterface

// File: rtl/id_stage.sv
// MIPS-subset decode stage: control decode, immediate/branch/jump targets, and a
// 32x32 register file written back through a 3-deep (wn, wreg) delay line.
module id_stage (
    input  logic       clk,
    input  logic       clrn,
    id_stage_if.slave  bus
);
    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [2:0]  aluc_s;
    logic        aluimm_s;
    logic        m2reg_s;
    logic        wmem_s;
    logic        shift_s;
    logic        wreg_s;
    logic        regrt_s;
    logic        zext_s;
    logic        beq_s;
    logic        bne_s;
    logic        take_s;
    logic [4:0]  wn_s;
    logic [31:0] sext_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic        we_s;

    logic [2:0][4:0] wn_q;
    logic [2:0][4:0] wn_d;
    logic [2:0]      wreg_q;
    logic [2:0]      wreg_d;
    logic [31:0]     regs_q [32];

    assign op_s    = bus.inst[31:26];
    assign rs_s    = bus.inst[25:21];
    assign rt_s    = bus.inst[20:16];
    assign rd_s    = bus.inst[15:11];
    assign funct_s = bus.inst[5:0];

    // Instruction decode; anything unrecognised (including j) leaves every control at zero.
    always_comb begin
        aluc_s   = 3'b000;
        aluimm_s = 1'b0;
        m2reg_s  = 1'b0;
        wmem_s   = 1'b0;
        shift_s  = 1'b0;
        wreg_s   = 1'b0;
        regrt_s  = 1'b0;
        zext_s   = 1'b0;
        beq_s    = 1'b0;
        bne_s    = 1'b0;
        case (op_s)
            6'b000000: begin
                case (funct_s)
                    6'b100000: begin aluc_s = 3'b000; wreg_s = 1'b1; end
                    6'b100010: begin aluc_s = 3'b001; wreg_s = 1'b1; end
                    6'b100100: begin aluc_s = 3'b010; wreg_s = 1'b1; end
                    6'b100101: begin aluc_s = 3'b011; wreg_s = 1'b1; end
                    6'b100110: begin aluc_s = 3'b100; wreg_s = 1'b1; end
                    6'b000000: begin aluc_s = 3'b101; wreg_s = 1'b1; shift_s = 1'b1; end
                    6'b000010: begin aluc_s = 3'b110; wreg_s = 1'b1; shift_s = 1'b1; end
                    6'b000011: begin aluc_s = 3'b111; wreg_s = 1'b1; shift_s = 1'b1; end
                    default:   begin aluc_s = 3'b000; wreg_s = 1'b0; end
                endcase
            end
            6'b001000: begin aluc_s = 3'b000; aluimm_s = 1'b1; wreg_s = 1'b1; regrt_s = 1'b1; end
            6'b001100: begin aluc_s = 3'b010; aluimm_s = 1'b1; wreg_s = 1'b1; regrt_s = 1'b1; zext_s = 1'b1; end
            6'b001101: begin aluc_s = 3'b011; aluimm_s = 1'b1; wreg_s = 1'b1; regrt_s = 1'b1; zext_s = 1'b1; end
            6'b001110: begin aluc_s = 3'b100; aluimm_s = 1'b1; wreg_s = 1'b1; regrt_s = 1'b1; zext_s = 1'b1; end
            6'b100011: begin aluc_s = 3'b000; aluimm_s = 1'b1; wreg_s = 1'b1; regrt_s = 1'b1; m2reg_s = 1'b1; end
            6'b101011: begin aluc_s = 3'b000; aluimm_s = 1'b1; wmem_s = 1'b1; end
            6'b000100: begin aluc_s = 3'b001; beq_s = 1'b1; end
            6'b000101: begin aluc_s = 3'b001; bne_s = 1'b1; end
            default:   begin aluc_s = 3'b000; end
        endcase
    end

    assign wn_s   = regrt_s ? rt_s : rd_s;
    assign sext_s = {{16{bus.inst[15]}}, bus.inst[15:0]};
    assign take_s = (beq_s & bus.rsrtequ) | (bne_s & ~bus.rsrtequ);

    assign bus.imm    = zext_s ? {16'h0000, bus.inst[15:0]} : sext_s;
    assign bus.bpc    = take_s ? (bus.pc4 + {sext_s[29:0], 2'b00}) : bus.pc4;
    assign bus.jpc    = {bus.pc4[31:28], bus.inst[25:0], 2'b00};
    assign bus.aluc   = aluc_s;
    assign bus.aluimm = aluimm_s;
    assign bus.m2reg  = m2reg_s;
    assign bus.wmem   = wmem_s;
    assign bus.shift  = shift_s;

    assign wn_d   = {wn_q[1:0], wn_s};
    assign wreg_d = {wreg_q[1:0], wreg_s};
    assign we_s   = wreg_q[2] & (wn_q[2] != 5'd0);

    // Write-destination delay line; stage 2 is the write retiring at this edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wn_q   <= 15'd0;
            wreg_q <= 3'b000;
        end else begin
            wn_q   <= wn_d;
            wreg_q <= wreg_d;
        end
    end

    // Register file storage; r0 is never written so it stays zero.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we_s) begin
            regs_q[wn_q[2]] <= bus.wdi;
        end
    end

    // Operand reads with bypass of the write landing this cycle.
    always_comb begin
        a_s = 32'd0;
        b_s = 32'd0;
        if (we_s && (wn_q[2] == rs_s)) begin
            a_s = bus.wdi;
        end else begin
            a_s = regs_q[rs_s];
        end
        if (we_s && (wn_q[2] == rt_s)) begin
            b_s = bus.wdi;
        end else begin
            b_s = regs_q[rt_s];
        end
    end

    assign bus.a = a_s;
    assign bus.b = b_s;
endmodule

// File: tb/tb_id_stage.sv
// Directed plus randomized check of id_stage against an instruction-level reference model.
module tb_id_stage;
    logic clk;
    logic clrn;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        bit       we;
        bit [4:0] wn;
    } wr_t;

    logic [31:0] mreg [32];
    wr_t         pend [$];

    id_stage_if ifc ();
    id_stage dut (.clk(clk), .clrn(clrn), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic string mnem(input logic [31:0] i);
        logic [5:0] op;
        logic [5:0] fn;
        op = i[31:26];
        fn = i[5:0];
        if (op == 6'd0) begin
            case (fn)
                6'h20: return "add";
                6'h22: return "sub";
                6'h24: return "and";
                6'h25: return "or";
                6'h26: return "xor";
                6'h00: return "sll";
                6'h02: return "srl";
                6'h03: return "sra";
                default: return "nop";
            endcase
        end
        case (op)
            6'h08: return "addi";
            6'h0c: return "andi";
            6'h0d: return "ori";
            6'h0e: return "xori";
            6'h23: return "lw";
            6'h2b: return "sw";
            6'h04: return "beq";
            6'h05: return "bne";
            6'h02: return "j";
            default: return "nop";
        endcase
    endfunction

    function automatic int m_aluc(input string nm);
        case (nm)
            "sub", "beq", "bne": return 1;
            "and", "andi":       return 2;
            "or", "ori":         return 3;
            "xor", "xori":       return 4;
            "sll":               return 5;
            "srl":               return 6;
            "sra":               return 7;
            default:             return 0;
        endcase
    endfunction

    function automatic bit is_rtype(input string nm);
        case (nm)
            "add", "sub", "and", "or", "xor", "sll", "srl", "sra": return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_iwrite(input string nm);
        case (nm)
            "addi", "andi", "ori", "xori", "lw": return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) mreg[r] = 32'd0;
        pend.delete();
        for (int k = 0; k < 3; k++) pend.push_back('{we: 1'b0, wn: 5'd0});
    endtask

    task automatic model_check(input string tag);
        logic [31:0] i, sx, e_bpc, e_jpc, e_imm, e_a, e_b, off;
        logic [4:0]  rs, rt;
        string       nm;
        wr_t         h;
        bit          taken, zx;
        i     = ifc.inst;
        nm    = mnem(i);
        rs    = i[25:21];
        rt    = i[20:16];
        off   = {16'd0, i[15:0]};
        sx    = (off >= 32'd32768) ? (off - 32'd65536) : off;
        zx    = (nm == "andi") || (nm == "ori") || (nm == "xori");
        e_imm = zx ? off : sx;
        taken = ((nm == "beq") && ifc.rsrtequ) || ((nm == "bne") && !ifc.rsrtequ);
        e_bpc = taken ? (ifc.pc4 + sx * 32'd4) : ifc.pc4;
        e_jpc = (ifc.pc4 & 32'hF000_0000) | ({6'd0, i[25:0]} * 32'd4);
        h     = pend[0];
        e_a   = (h.we && h.wn != 5'd0 && h.wn == rs) ? ifc.wdi : mreg[rs];
        e_b   = (h.we && h.wn != 5'd0 && h.wn == rt) ? ifc.wdi : mreg[rt];
        chk({tag, ".a"}, ifc.a, e_a);
        chk({tag, ".b"}, ifc.b, e_b);
        chk({tag, ".imm"}, ifc.imm, e_imm);
        chk({tag, ".bpc"}, ifc.bpc, e_bpc);
        chk({tag, ".jpc"}, ifc.jpc, e_jpc);
        chk({tag, ".aluc"}, {29'd0, ifc.aluc}, 32'(m_aluc(nm)));
        chk({tag, ".aluimm"}, {31'd0, ifc.aluimm},
            {31'd0, (is_iwrite(nm) || nm == "sw")});
        chk({tag, ".m2reg"}, {31'd0, ifc.m2reg}, {31'd0, (nm == "lw")});
        chk({tag, ".wmem"}, {31'd0, ifc.wmem}, {31'd0, (nm == "sw")});
        chk({tag, ".shift"}, {31'd0, ifc.shift},
            {31'd0, (nm == "sll" || nm == "srl" || nm == "sra")});
    endtask

    task automatic apply(input logic [31:0] i, input logic [31:0] p, input bit eq,
                         input logic [31:0] w, input string tag);
        ifc.inst    = i;
        ifc.pc4     = p;
        ifc.rsrtequ = eq;
        ifc.wdi     = w;
        #4;
        model_check(tag);
    endtask

    task automatic advance();
        wr_t   h;
        string nm;
        @(posedge clk);
        if (clrn) begin
            h = pend.pop_front();
            if (h.we && h.wn != 5'd0) mreg[h.wn] = ifc.wdi;
            nm = mnem(ifc.inst);
            pend.push_back('{we: (is_rtype(nm) || is_iwrite(nm)),
                             wn: (is_rtype(nm) ? ifc.inst[15:11] : ifc.inst[20:16])});
        end
        #1;
    endtask

    task automatic random_steps(input int n);
        bit [5:0]    rfn [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03};
        bit [5:0]    iop [9] = '{6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};
        logic [31:0] i;
        int          k;
        for (int s = 0; s < n; s++) begin
            k = int'($urandom_range(0, 19));
            if (k < 8) begin
                i = {6'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom), rfn[k]};
            end else if (k < 17) begin
                i = {iop[k-8], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            end else begin
                i = $urandom;
            end
            apply(i, $urandom & 32'hFFFF_FFFC, 1'($urandom), $urandom, "rand");
            advance();
        end
    endtask

    initial begin
        clrn = 1'b0;
        model_reset();
        apply(32'h0064_2820, 32'h0000_0004, 1'b0, 32'hDEAD_BEEF, "reset");
        chk("reset_a", ifc.a, 32'd0);
        chk("reset_b", ifc.b, 32'd0);
        chk("reset_aluc", {29'd0, ifc.aluc}, 32'd0);
        advance();
        advance();
        clrn = 1'b1;

        apply(32'h2001_0005, 32'h0000_0004, 1'b0, 32'd0, "wb_addi");
        advance();
        apply(32'h0000_0000, 32'h0000_0008, 1'b0, 32'd0, "wb_nop1");
        advance();
        apply(32'h0000_0000, 32'h0000_000C, 1'b0, 32'd0, "wb_nop2");
        advance();
        apply(32'h0000_0000, 32'h0000_0010, 1'b0, 32'd5, "wb_nop3");
        advance();
        apply(32'h0021_1020, 32'h0000_0014, 1'b0, 32'd0, "wb_read");
        chk("wb_read_a", ifc.a, 32'd5);
        chk("wb_read_b", ifc.b, 32'd5);
        advance();

        apply(32'h2000_0007, 32'h0000_0018, 1'b0, 32'd0, "r0_addi");
        advance();
        for (int n = 0; n < 3; n++) begin
            apply(32'h0000_0000, 32'h0000_001C, 1'b0, 32'd7, "r0_nop");
            advance();
        end
        apply(32'h0000_1820, 32'h0000_0020, 1'b0, 32'd0, "r0_read");
        chk("r0_read_a", ifc.a, 32'd0);
        advance();

        apply(32'h10E8_0002, 32'h0000_0008, 1'b1, 32'd0, "beq_t");
        chk("beq_taken_bpc", ifc.bpc, 32'h0000_0010);
        chk("beq_aluc", {29'd0, ifc.aluc}, 32'd1);
        advance();
        apply(32'h10E8_0002, 32'h0000_0008, 1'b0, 32'd0, "beq_nt");
        chk("beq_not_taken_bpc", ifc.bpc, 32'h0000_0008);
        advance();
        apply(32'h14E8_0002, 32'h0000_0008, 1'b1, 32'd0, "bne_nt");
        chk("bne_not_taken_bpc", ifc.bpc, 32'h0000_0008);
        advance();
        apply(32'h14E8_0002, 32'h0000_0008, 1'b0, 32'd0, "bne_t");
        chk("bne_taken_bpc", ifc.bpc, 32'h0000_0010);
        advance();

        apply(32'h2001_FFFF, 32'h0000_0040, 1'b0, 32'd0, "addi_sx");
        chk("addi_imm", ifc.imm, 32'hFFFF_FFFF);
        chk("addi_aluimm", {31'd0, ifc.aluimm}, 32'd1);
        advance();
        apply(32'h3401_FFFF, 32'h0000_0044, 1'b0, 32'd0, "ori_zx");
        chk("ori_imm", ifc.imm, 32'h0000_FFFF);
        chk("ori_aluc", {29'd0, ifc.aluc}, 32'd3);
        advance();
        apply(32'h8C22_0004, 32'h0000_0048, 1'b0, 32'd0, "lw");
        chk("lw_m2reg", {31'd0, ifc.m2reg}, 32'd1);
        advance();
        apply(32'hAC22_0004, 32'h0000_004C, 1'b0, 32'd0, "sw");
        chk("sw_wmem", {31'd0, ifc.wmem}, 32'd1);
        advance();
        apply(32'h0800_0100, 32'h1000_0004, 1'b0, 32'd0, "j");
        chk("j_jpc", ifc.jpc, 32'h1000_0400);
        advance();
        apply(32'h0003_1080, 32'h0000_0050, 1'b0, 32'd0, "sll");
        chk("sll_shift", {31'd0, ifc.shift}, 32'd1);
        chk("sll_aluc", {29'd0, ifc.aluc}, 32'd5);
        chk("sll_shamt", {27'd0, ifc.imm[10:6]}, 32'd2);
        advance();

        random_steps(200);

        clrn = 1'b0;
        model_reset();
        apply(32'h0021_1020, 32'h0000_0100, 1'b0, 32'h1234_5678, "midreset");
        chk("midreset_a", ifc.a, 32'd0);
        advance();
        clrn = 1'b1;

        random_steps(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named as follows.
- clk, input, 1: rising-edge clock.
- clrn, input, 1: asynchronous active-low reset.

REQ-002 The block SHALL have these data and control ports.
- pc4, input, 32: PC+4 of the instruction in decode.
- inst, input, 32: instruction in decode.
- wdi, input, 32: write-back data from the WB stage.
- rsrtequ, input, 1: 1 when rs==rt, as computed outside this block.
- bpc, output, 32: branch next-PC.
- jpc, output, 32: jump target.
- a, output, 32: rs operand.
- b, output, 32: rt operand.
- imm, output, 32: extended immediate.
- aluc, output, 3: ALU operation code.
- m2reg, output, 1: load result comes from memory.
- wmem, output, 1: memory write.
- aluimm, output, 1: ALU B operand is imm.
- shift, output, 1: ALU A operand is the shift amount, imm[10:6].

Function
REQ-003 Decoding SHALL follow standard MIPS fields: op=inst[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].

REQ-004 The block SHALL support these instructions and no others.
- R-type (op=0), by funct: add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011.
- I-type, by op: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101.
- J-type: j 000010.

REQ-005 aluc SHALL be encoded as follows.
- add/addi/lw/sw = 000.
- sub/beq/bne = 001.
- and/andi = 010.
- or/ori = 011.
- xor/xori = 100.
- sll = 101, srl = 110, sra = 111.

REQ-006 Control outputs SHALL decode as follows.
- aluimm = 1 for addi/andi/ori/xori/lw/sw.
- m2reg = 1 for lw only.
- wmem = 1 for sw only.
- shift = 1 for sll/srl/sra.

REQ-007 Any unsupported encoding SHALL decode as a no-op: aluc=000, all flags 0, no register write.

REQ-008 imm SHALL be zero-extended inst[15:0] for andi/ori/xori, and sign-extended inst[15:0] for all other encodings.

REQ-009 jpc SHALL equal {pc4[31:28], inst[25:0], 2'b00} for every instruction.

REQ-010 bpc SHALL be computed as follows.
- bpc = pc4 + (sign-extended inst[15:0] << 2) when beq with rsrtequ=1, or bne with rsrtequ=0.
- bpc = pc4 otherwise.
- Addition SHALL wrap modulo 2^32.

REQ-011 The block SHALL contain a 32x32 register file with r0 hardwired to 0.
- Reads SHALL be combinational: a = reg[rs], b = reg[rt].

REQ-012 Each decoded instruction SHALL generate a write-register number wn and a write enable wreg.
- wn = rd for R-type; wn = rt for addi/andi/ori/xori/lw.
- wreg = 1 for all R-type ALU ops and those I-types; wreg = 0 otherwise.

REQ-013 (wn, wreg) SHALL pass through an internal 3-register delay line clocked on the rising edge.
- An instruction in decode during cycle n SHALL write wdi into reg[wn] at the rising edge ending cycle n+3, if its wreg=1 and wn≠0.

REQ-014 Register reads SHALL bypass a same-cycle write: when the delayed write is enabled and its wn equals rs (or rt), a (or b) SHALL equal wdi.

REQ-015 The decode logic and the bpc/jpc/imm logic SHALL be purely combinational, with zero-cycle latency from inst, pc4 and rsrtequ.

Reset
REQ-016 While clrn=0, all 32 registers and all three delay-line stages SHALL clear to 0, asynchronously.
- Consequently a=b=0 during reset, and no register write occurs in the first 3 cycles after reset release.

REQ-017 Combinational outputs SHALL remain valid during reset; only a and b are forced by the cleared register file.

Verification
REQ-018 Reset with clrn=0, inst=0x00642820 -> a=0, b=0; aluc=000 and all flags 0 (add r5,r3,r4).

REQ-019 Branch taken vs. not taken: inst=0x10E80002, pc4=0x00000008.
- rsrtequ=1 -> bpc=0x00000010, aluc=001.
- rsrtequ=0 -> bpc=0x00000008.
- Same inst with op changed to bne (0x14E80002) -> the bpc results invert.

REQ-020 Immediate extension:
- inst=0x2001FFFF -> imm=0xFFFFFFFF, aluimm=1.
- inst=0x3401FFFF -> imm=0x0000FFFF, aluc=011.
- inst=0x8C220004 -> m2reg=1.
- inst=0xAC220004 -> wmem=1.

REQ-021 Jump and shift:
- inst=0x08000100, pc4=0x10000004 -> jpc=0x10000400.
- inst=0x00031080 (sll) -> shift=1, aluc=101, imm[10:6]=2.

REQ-022 Write-back timing: after reset release, apply addi r1,r0,5 (0x20010005), then 3 cycles of inst=0, with wdi=5 during the third.
- Next cycle, inst=0x00211020 -> a=b=5.
- A write targeting r0 -> r0 still reads 0.
